traffic_injector: RTL and testbench

TRAFFIC_INJECTOR -- requirements
Module: traffic_injector

---
 rtl/traffic_injector.sv | 127 ++++++++++++
 tb/tb_traffic_injector.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_injector.sv
// Synthetic flit source: LFSR-chosen destination plus a running sequence number,
// rate-limited by a gap counter and buffered in a small FIFO toward a router rx port.
module traffic_injector #(
    parameter int         SIZE             = 8,
    parameter int         DESTINATION_BITS = 3,
    parameter int         ID               = 0,
    parameter int         GAP              = 3,
    parameter int         DEPTH_LOG2       = 2,
    parameter logic [7:0] SEED             = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    output logic            tx_req,
    input  logic            tx_ack,
    output logic [SIZE-1:0] tx_data,
    output logic [15:0]     sent_count,
    output logic [15:0]     stall_count
);

    localparam int SEQ_BITS = SIZE - DESTINATION_BITS;
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int GAP_BITS = (GAP > 0) ? $clog2(GAP + 1) : 1;

    // An all-zero seed would lock the LFSR up, so it is promoted to 1.
    localparam logic [7:0]                  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [DESTINATION_BITS-1:0] ID_DEST  = DESTINATION_BITS'(ID);
    localparam logic [DESTINATION_BITS-1:0] ID_ALT   = DESTINATION_BITS'(ID + 1);
    localparam logic [GAP_BITS-1:0]         GAP_LOAD = GAP_BITS'(GAP);

    logic [7:0]            lfsr_q, lfsr_d;
    logic [SEQ_BITS-1:0]   seq_q, seq_d;
    logic [GAP_BITS-1:0]   gap_q, gap_d;
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]           sent_q, sent_d;
    logic [15:0]           stall_q, stall_d;
    logic [SIZE-1:0]       mem_q [DEPTH];

    logic                        empty;
    logic                        full;
    logic                        gen;
    logic                        push;
    logic                        pop;
    logic                        blocked;
    logic                        lfsr_fb;
    logic [DESTINATION_BITS-1:0] dest_raw;
    logic [DESTINATION_BITS-1:0] dest;
    logic [SIZE-1:0]             flit;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        pop     = !empty && tx_ack;
        gen     = (gap_q == '0) && enable;
        // Full is judged on registered pointers, so a same-cycle pop never frees a slot.
        push    = gen && !full;
        blocked = gen && full;

        lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        dest_raw = lfsr_q[DESTINATION_BITS-1:0];
        dest     = (dest_raw == ID_DEST) ? ID_ALT : dest_raw;
        flit     = {dest, seq_q};
    end

    always_comb begin
        lfsr_d   = lfsr_q;
        seq_d    = seq_q;
        gap_d    = gap_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sent_d   = sent_q;
        stall_d  = stall_q;

        if (push) begin
            lfsr_d   = {lfsr_q[6:0], lfsr_fb};
            seq_d    = seq_q + 1'b1;
            gap_d    = GAP_LOAD;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            sent_d   = sent_q + 16'd1;
        end

        if (blocked && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= SEED_EFF;
            seq_q    <= '0;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sent_q   <= '0;
            stall_q  <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            seq_q    <= seq_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sent_q   <= sent_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= flit;
        end
    end

    assign tx_req      = !empty;
    assign tx_data     = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign sent_count  = sent_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_traffic_injector.sv
// Bench for traffic_injector: directed vector table, hand-written corner sequences,
// and randomized enable/ack/reset against a queue-based reference model.
module tb_traffic_injector;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst   [NI];
    logic        en    [NI];
    logic        ack   [NI];
    logic        req   [NI];
    logic [7:0]  data  [NI];
    logic [15:0] sent  [NI];
    logic [15:0] stall [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u0: defaults; u1: GAP=0 with ID=5; u2/u3: SEED 0 versus SEED 1.
    traffic_injector #(.SIZE(8), .DESTINATION_BITS(3), .ID(0), .GAP(3), .DEPTH_LOG2(2), .SEED(8'hA5)) u0 (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .tx_req(req[0]), .tx_ack(ack[0]),
        .tx_data(data[0]), .sent_count(sent[0]), .stall_count(stall[0]));
    traffic_injector #(.SIZE(8), .DESTINATION_BITS(3), .ID(5), .GAP(0), .DEPTH_LOG2(2), .SEED(8'hA5)) u1 (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .tx_req(req[1]), .tx_ack(ack[1]),
        .tx_data(data[1]), .sent_count(sent[1]), .stall_count(stall[1]));
    traffic_injector #(.SIZE(8), .DESTINATION_BITS(3), .ID(0), .GAP(0), .DEPTH_LOG2(2), .SEED(8'h00)) u2 (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .tx_req(req[2]), .tx_ack(ack[2]),
        .tx_data(data[2]), .sent_count(sent[2]), .stall_count(stall[2]));
    traffic_injector #(.SIZE(8), .DESTINATION_BITS(3), .ID(0), .GAP(0), .DEPTH_LOG2(2), .SEED(8'h01)) u3 (
        .clk(clk), .reset(rst[3]), .enable(en[3]), .tx_req(req[3]), .tx_ack(ack[3]),
        .tx_data(data[3]), .sent_count(sent[3]), .stall_count(stall[3]));

    function automatic int p_gap(int i);
        return (i == 0) ? 3 : 0;
    endfunction

    function automatic int p_id(int i);
        return (i == 1) ? 5 : 0;
    endfunction

    function automatic int p_seed(int i);
        case (i)
            2:       return 8'h00;
            3:       return 8'h01;
            default: return 8'hA5;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_next(logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    int         m_gap   [NI];
    int         m_seq   [NI];
    int         m_sent  [NI];
    int         m_stall [NI];
    logic [7:0] m_lfsr  [NI];
    int         m_q     [NI][$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_edge(int i);
        bit was_full;
        bit gen;
        int dest;
        if (rst[i]) begin
            m_q[i].delete();
            m_gap[i]   = 0;
            m_seq[i]   = 0;
            m_sent[i]  = 0;
            m_stall[i] = 0;
            m_lfsr[i]  = (p_seed(i) == 0) ? 8'h01 : 8'(p_seed(i));
        end else begin
            was_full = (m_q[i].size() == 4);
            gen      = (m_gap[i] == 0) && en[i];
            if (m_q[i].size() > 0 && ack[i]) begin
                void'(m_q[i].pop_front());
                m_sent[i] = (m_sent[i] + 1) % 65536;
            end
            if (gen && !was_full) begin
                dest = int'(m_lfsr[i]) % 8;
                if (dest == p_id(i)) dest = (dest + 1) % 8;
                m_q[i].push_back(dest * 32 + m_seq[i]);
                m_seq[i]  = (m_seq[i] + 1) % 32;
                m_lfsr[i] = lfsr_next(m_lfsr[i]);
                m_gap[i]  = p_gap(i);
            end else if (m_gap[i] > 0) begin
                m_gap[i]--;
            end
            if (gen && was_full && m_stall[i] < 65535) m_stall[i]++;
        end
    endtask

    task automatic model_check(int i);
        chk($sformatf("u%0d model req", i), int'(req[i]), (m_q[i].size() > 0) ? 1 : 0);
        if (m_q[i].size() > 0) chk($sformatf("u%0d model data", i), int'(data[i]), m_q[i][0]);
        chk($sformatf("u%0d model sent", i), int'(sent[i]), m_sent[i]);
        chk($sformatf("u%0d model stall", i), int'(stall[i]), m_stall[i]);
    endtask

    // One rising edge: advance the model on the sampled inputs, then compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i);
        #1;
        for (int i = 0; i < NI; i++) model_check(i);
    endtask

    typedef struct {
        bit rst;
        bit en;
        bit ack;
        bit exp_req;
        bit chk_data;
        int exp_data;
        int exp_sent;
        int exp_stall;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(bit r, bit e, bit a, bit xr, bit cd, int xd, int xs, int xst);
        vec_t v;
        v.rst = r; v.en = e; v.ack = a; v.exp_req = xr; v.chk_data = cd;
        v.exp_data = xd; v.exp_sent = xs; v.exp_stall = xst;
        return v;
    endfunction

    initial begin
        int exp_seq[3];

        // u0 from reset release, enable=1, ack=1: push every 4 edges, each flit taken next edge.
        tbl[0] = mk(1, 1, 1, 0, 1, 8'h00, 0, 0);
        for (int r = 1; r <= 16; r++) tbl[r] = mk(0, 1, 1, 0, 0, 0, (r - 1) / 4 + ((r - 1) % 4 != 0 ? 1 : 0), 0);
        tbl[1].exp_req  = 1; tbl[1].chk_data  = 1; tbl[1].exp_data  = 8'hA0;
        tbl[5].exp_req  = 1; tbl[5].chk_data  = 1; tbl[5].exp_data  = 8'h41;
        tbl[9].exp_req  = 1; tbl[9].chk_data  = 1; tbl[9].exp_data  = 8'hA2;
        tbl[13].exp_req = 1; tbl[13].chk_data = 1; tbl[13].exp_data = 8'h43;

        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; ack[i] = 1'b0;
        end
        step();
        step();

        for (int r = 0; r < 17; r++) begin
            rst[0] = tbl[r].rst; en[0] = tbl[r].en; ack[0] = tbl[r].ack;
            step();
            chk($sformatf("tbl[%0d] req", r), int'(req[0]), int'(tbl[r].exp_req));
            if (tbl[r].chk_data) chk($sformatf("tbl[%0d] data", r), int'(data[0]), tbl[r].exp_data);
            chk($sformatf("tbl[%0d] sent", r), int'(sent[0]), tbl[r].exp_sent);
            chk($sformatf("tbl[%0d] stall", r), int'(stall[0]), tbl[r].exp_stall);
        end

        // enable low: nothing generated, no stalls; raising it pushes on the very next edge.
        rst[0] = 1'b1; step();
        rst[0] = 1'b0; en[0] = 1'b0; ack[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("idle req", int'(req[0]), 0);
            chk("idle stall", int'(stall[0]), 0);
        end
        en[0] = 1'b1;
        step();
        chk("enable first req", int'(req[0]), 1);
        chk("enable first data", int'(data[0]), 8'hA0);

        // Queue three flits, then a one-cycle reset discards them and restarts the LFSR.
        ack[0] = 1'b0;
        repeat (8) step();
        chk("pre-reset req", int'(req[0]), 1);
        chk("pre-reset head", int'(data[0]), 8'hA0);
        rst[0] = 1'b1;
        step();
        chk("mid reset req", int'(req[0]), 0);
        chk("mid reset data", int'(data[0]), 0);
        chk("mid reset sent", int'(sent[0]), 0);
        chk("mid reset stall", int'(stall[0]), 0);
        rst[0] = 1'b0; ack[0] = 1'b1;
        step();
        chk("post reset data", int'(data[0]), 8'hA0);
        rst[0] = 1'b1;

        // GAP=0, ack low: four flits fill the queue, six blocked cycles, head held at seq 0.
        rst[1] = 1'b1; step();
        rst[1] = 1'b0; en[1] = 1'b1; ack[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("hold req %0d", k), int'(req[1]), 1);
            chk($sformatf("hold data %0d", k), int'(data[1]), 8'hC0);
        end
        chk("full stall", int'(stall[1]), 6);
        chk("full sent", int'(sent[1]), 0);
        en[1] = 1'b0; ack[1] = 1'b1;
        exp_seq[0] = 8'h41; exp_seq[1] = 8'hC2; exp_seq[2] = 8'h43;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("drain data %0d", k + 1), int'(data[1]), exp_seq[k]);
        end
        step();
        chk("drained req", int'(req[1]), 0);
        chk("drained sent", int'(sent[1]), 4);
        chk("drained stall", int'(stall[1]), 6);

        // GAP=0 with ack high: one flit per cycle, sequence wraps 31 -> 0.
        rst[1] = 1'b1; step();
        rst[1] = 1'b0; en[1] = 1'b1; ack[1] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            chk($sformatf("wrap req %0d", k), int'(req[1]), 1);
            chk($sformatf("wrap seq %0d", k), int'(data[1][4:0]), k % 32);
        end
        chk("wrap sent", int'(sent[1]), 39);

        // Random traffic on all instances, including the SEED 0 / SEED 1 pair.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NI; i++) begin
                rst[i] = ($urandom_range(99) == 0);
                en[i]  = ($urandom_range(3) != 0);
                ack[i] = ($urandom_range(4) < 3);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
